// File: rtl/dff_r_if.sv
// dff_r_if -- data bundle for the dff_r register.
//   Parameter WIDTH : register width in bits (1..32).
//   d  : next-state data (driven by master).
//   q  : registered data (driven by slave, i.e. the register).
//   en : load enable, present only when DFF_R_LOAD_EN is defined.
// Modports: master (drives d/en, observes q), slave (the register).
interface dff_r_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef DFF_R_LOAD_EN
  logic             en;
`endif

  modport master (
`ifdef DFF_R_LOAD_EN
    output en,
`endif
    output d,
    input  q
  );

  modport slave (
`ifdef DFF_R_LOAD_EN
    input  en,
`endif
    input  d,
    output q
  );

endinterface : dff_r_if

// File: rtl/dff_r.sv
// dff_r -- WIDTH-bit register with asynchronous active-low reset.
//   Parameters:
//     WIDTH   : register width in bits, legal range 1..32.
//     RST_VAL : value forced onto q while reset_n is low.
//   Ports:
//     clk     : single clock, rising-edge active.
//     reset_n : asynchronous, active-low reset.
//     bus     : dff_r_if slave modport carrying d (in), q (out) and,
//               optionally, en (in).
//   Configuration macro:
//     DFF_R_LOAD_EN : when defined, q loads d only on edges where en=1;
//                     when undefined, q loads d on every rising edge.
// q comes straight from the flops; the only state in the block is q.
module dff_r #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic   clk,
  input  logic   reset_n,
  dff_r_if.slave bus
);

  logic [WIDTH-1:0] q_r;

  // Reset wins over any capture; d is copied bit-for-bit with no filtering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= RST_VAL;
`ifdef DFF_R_LOAD_EN
    end else if (bus.en) begin
      q_r <= bus.d;
`else
    end else begin
      q_r <= bus.d;
`endif
    end
  end

  assign bus.q = q_r;

endmodule : dff_r

// File: tb/tb_dff_r.sv
// tb_dff_r -- directed self-checking bench for dff_r.
// Three instances share clk/reset_n: 3-bit default reset value, 4-bit
// default reset value, and 3-bit with RST_VAL=3'b001.
module tb_dff_r;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] wrap_vals [4];

  always #5 clk = ~clk;

  dff_r_if #(.WIDTH(3)) if3  ();
  dff_r_if #(.WIDTH(4)) if4  ();
  dff_r_if #(.WIDTH(3)) if3r ();

  dff_r #(.WIDTH(3)) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3)
  );

  dff_r #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if4)
  );

  dff_r #(.WIDTH(3), .RST_VAL(3'b001)) u_dut3r (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3r)
  );

  // Reset held for two cycles with d=101, then release and capture.
  task automatic test_reset();
    reset_n = 1'b0;
    if3.d   = 3'b101;
    if4.d   = 4'b1111;
    if3r.d  = 3'b110;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if3.q !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_hold_w3 cycle %0d: got %b want 000", i, if3.q);
      end
      n_cmp++;
      if (if4.q !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_hold_w4 cycle %0d: got %b want 0000", i, if4.q);
      end
      n_cmp++;
      if (if3r.q !== 3'b001) begin
        n_bad++;
        $display("FAIL reset_value_rst001 cycle %0d: got %b want 001", i, if3r.q);
      end
    end
    reset_n = 1'b1;
    if3.d   = 3'b101;
    @(negedge clk);
    n_cmp++;
    if (if3.q !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_release_capture: got %b want 101", if3.q);
    end
    n_cmp++;
    if (if3r.q !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_release_capture_rst001: got %b want 110", if3r.q);
    end
  endtask

  // Successive values follow one edge later and hold while d wiggles.
  task automatic test_capture_wrap();
    for (int i = 0; i < 4; i++) begin
      if4.d = wrap_vals[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (if4.q !== wrap_vals[i]) begin
        n_bad++;
        $display("FAIL capture_w4 step %0d: got %b want %b", i, if4.q, wrap_vals[i]);
      end
      if4.d = ~wrap_vals[i];
      @(negedge clk);
      n_cmp++;
      if (if4.q !== wrap_vals[i]) begin
        n_bad++;
        $display("FAIL hold_between_edges step %0d: got %b want %b", i, if4.q, wrap_vals[i]);
      end
    end
  endtask

  // Reset pulled low mid-cycle must clear q without a clock edge.
  task automatic test_async_reset();
    if4.d = 4'b1000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (if4.q !== 4'b1000) begin
      n_bad++;
      $display("FAIL async_preload: got %b want 1000", if4.q);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (if4.q !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_clear_before_edge: got %b want 0000", if4.q);
    end
    n_cmp++;
    if (if3r.q !== 3'b001) begin
      n_bad++;
      $display("FAIL async_reset_value_rst001: got %b want 001", if3r.q);
    end
    if4.d = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if4.q !== 4'b0000) begin
        n_bad++;
        $display("FAIL async_hold_low cycle %0d: got %b want 0000", i, if4.q);
      end
    end
    reset_n = 1'b1;
    if4.d   = 4'b0101;
    @(negedge clk);
    n_cmp++;
    if (if4.q !== 4'b0101) begin
      n_bad++;
      $display("FAIL first_edge_after_release: got %b want 0101", if4.q);
    end
  endtask

  // reset_n rises in the same time step as a clk edge: that edge is ignored.
  task automatic test_release_coincident();
    reset_n = 1'b0;
    if3.d   = 3'b011;
    @(negedge clk);
    n_cmp++;
    if (if3.q !== 3'b000) begin
      n_bad++;
      $display("FAIL coincident_pre: got %b want 000", if3.q);
    end
    @(posedge clk);
    reset_n <= 1'b1;
    #1;
    n_cmp++;
    if (if3.q !== 3'b000) begin
      n_bad++;
      $display("FAIL coincident_edge_ignored: got %b want 000", if3.q);
    end
    @(negedge clk);
    n_cmp++;
    if (if3.q !== 3'b000) begin
      n_bad++;
      $display("FAIL coincident_hold: got %b want 000", if3.q);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (if3.q !== 3'b011) begin
      n_bad++;
      $display("FAIL coincident_next_edge: got %b want 011", if3.q);
    end
    @(negedge clk);
  endtask

  // All-ones followed by all-zeros registers unchanged.
  task automatic test_back_to_back();
    if3.d = 3'b111;
    @(negedge clk);
    n_cmp++;
    if (if3.q !== 3'b111) begin
      n_bad++;
      $display("FAIL b2b_ones: got %b want 111", if3.q);
    end
    if3.d = 3'b000;
    @(negedge clk);
    n_cmp++;
    if (if3.q !== 3'b000) begin
      n_bad++;
      $display("FAIL b2b_zeros: got %b want 000", if3.q);
    end
  endtask

`ifdef DFF_R_LOAD_EN
  // en=0 holds q across edges; en=1 loads; reset beats en.
  task automatic test_load_en();
    if4.en = 1'b1;
    if4.d  = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (if4.q !== 4'b0010) begin
      n_bad++;
      $display("FAIL load_en_preload: got %b want 0010", if4.q);
    end
    if4.en = 1'b0;
    if4.d  = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if4.q !== 4'b0010) begin
        n_bad++;
        $display("FAIL load_en_hold edge %0d: got %b want 0010", i, if4.q);
      end
    end
    if4.en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (if4.q !== 4'b1010) begin
      n_bad++;
      $display("FAIL load_en_load: got %b want 1010", if4.q);
    end
    if4.en  = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (if4.q !== 4'b0000) begin
      n_bad++;
      $display("FAIL load_en_reset_priority: got %b want 0000", if4.q);
    end
    @(negedge clk);
    reset_n = 1'b1;
    if4.en  = 1'b1;
  endtask
`endif

  initial begin
    wrap_vals[0] = 4'b0111;
    wrap_vals[1] = 4'b1000;
    wrap_vals[2] = 4'b1111;
    wrap_vals[3] = 4'b0000;
    reset_n = 1'b0;
    if3.d   = '0;
    if4.d   = '0;
    if3r.d  = '0;
`ifdef DFF_R_LOAD_EN
    if3.en  = 1'b1;
    if4.en  = 1'b1;
    if3r.en = 1'b1;
`endif
    test_reset();
    test_capture_wrap();
    test_async_reset();
    test_release_coincident();
    test_back_to_back();
`ifdef DFF_R_LOAD_EN
    test_load_en();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dff_r
